vga_pixel_selector: RTL and testbench

- Drives the colour multiplexer. Generates 640x480@60 Hz VGA timing from the system clock.
- For every active pixel, classifies it as background, 3x3 board grid line, cursor sprite or test fill, and emits the matching 3-bit selector code.
- The colour mux registers its output one clock after the selector. This block therefore delays hsync/vsync/blank_n so they stay aligned with the 24-bit RGB word.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing.sv | 63 ++++++
 rtl/vga_pixel_selector.sv | 122 ++++++++++++
 tb/tb_vga_pixel_selector.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour-mux selector codes and sync pipeline type
package vga_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [2:0] {
        SEL_FONDO  = 3'b000,
        SEL_PRU    = 3'b001,
        SEL_LINEAS = 3'b010,
        SEL_SPRIT  = 3'b011
    } sel_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, h/v counters and raw sync/active decode
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       active
);

    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing: totals exceed 10-bit counters");
    end

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          h_wrap, v_wrap;

    always_comb begin
        pix_en = div_q == DW'(CLK_DIV - 1);
        h_wrap = h_q == 10'(H_TOTAL - 1);
        v_wrap = v_q == 10'(V_TOTAL - 1);
        div_d  = pix_en ? '0 : div_q + DW'(1);
        h_d    = !pix_en ? h_q : h_wrap ? '0 : h_q + 10'd1;
        v_d    = !(pix_en && h_wrap) ? v_q : v_wrap ? '0 : v_q + 10'd1;
        hs_raw = !(h_q >= 10'(H_ACTIVE + H_FP) && h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
        vs_raw = !(v_q >= 10'(V_ACTIVE + V_FP) && v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
        active = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
        h_cnt  = h_q;
        v_cnt  = v_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

endmodule

// File: rtl/vga_pixel_selector.sv
// vga_pixel_selector: classifies each pixel (background/grid/sprite/test) and aligns syncs to the registered colour mux
module vga_pixel_selector
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int BOARD_X0   = 170,
    parameter int BOARD_Y0   = 90,
    parameter int CELL       = 100,
    parameter int LINE_W     = 4,
    parameter int SPR_MARGIN = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cur_col,
    input  logic [1:0] cur_row,
    input  logic       test_en,
    output logic [2:0] selector,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_start
);

    localparam int P    = CELL + LINE_W;
    localparam int SPAN = 3 * P + LINE_W;

    if (BOARD_X0 + SPAN > H_ACTIVE) begin : g_bad_board
        $error("vga_pixel_selector: board exceeds active width");
    end

    logic       pix_en, hs_raw, vs_raw, active;
    logic [9:0] h_cnt, v_cnt;
    logic [1:0] col_q, col_d, row_q, row_d;
    logic       frame_start_q, frame_start_d;
    logic       in_bx, in_by, on_vl, on_hl, spr_x, spr_y;
    sel_t       sel_q, sel_d;
    sync_t      s1_q, s1_d, s2_q, s2_d;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .hs_raw(hs_raw),
        .vs_raw(vs_raw),
        .active(active)
    );

    // All board bounds unroll to constants; a cursor value of 3 matches no cell
    always_comb begin
        frame_start_d = pix_en && h_cnt == '0 && v_cnt == '0;
        col_d = frame_start_d ? cur_col : col_q;
        row_d = frame_start_d ? cur_row : row_q;
        in_bx = h_cnt >= 10'(BOARD_X0) && h_cnt < 10'(BOARD_X0 + SPAN);
        in_by = v_cnt >= 10'(BOARD_Y0) && v_cnt < 10'(BOARD_Y0 + SPAN);
        on_vl = 1'b0;
        on_hl = 1'b0;
        spr_x = 1'b0;
        spr_y = 1'b0;
        for (int k = 0; k < 4; k++) begin
            on_vl |= h_cnt >= 10'(BOARD_X0 + k * P) && h_cnt < 10'(BOARD_X0 + k * P + LINE_W);
            on_hl |= v_cnt >= 10'(BOARD_Y0 + k * P) && v_cnt < 10'(BOARD_Y0 + k * P + LINE_W);
        end
        for (int k = 0; k < 3; k++) begin
            spr_x |= col_q == 2'(k) && h_cnt >= 10'(BOARD_X0 + LINE_W + k * P + SPR_MARGIN)
                     && h_cnt < 10'(BOARD_X0 + LINE_W + k * P + CELL - SPR_MARGIN);
            spr_y |= row_q == 2'(k) && v_cnt >= 10'(BOARD_Y0 + LINE_W + k * P + SPR_MARGIN)
                     && v_cnt < 10'(BOARD_Y0 + LINE_W + k * P + CELL - SPR_MARGIN);
        end
        sel_d = !active ? SEL_FONDO
              : test_en ? SEL_PRU
              : (spr_x && spr_y) ? SEL_SPRIT
              : ((on_vl && in_by) || (on_hl && in_bx)) ? SEL_LINEAS
              : SEL_FONDO;
        s1_d = '{hs: hs_raw, vs: vs_raw, act: active};
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q         <= 2'd3;
            row_q         <= 2'd3;
            frame_start_q <= 1'b0;
            sel_q         <= SEL_FONDO;
            s1_q          <= SYNC_IDLE;
            s2_q          <= SYNC_IDLE;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
            sel_q         <= sel_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
        end
    end

    assign selector    = sel_q;
    assign hsync       = s2_q.hs;
    assign vsync       = s2_q.vs;
    assign blank_n     = s2_q.act;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_selector.sv
// tb_vga_pixel_selector: directed checks on a shrunken-timing instance plus default-timing line checks
module tb_vga_pixel_selector;

    // Shrunken config: 56x37 pixel frame, board at (5,1), 8-px cells, 1-px lines, 2-px sprite inset
    localparam int HT = 56;
    localparam int F  = HT * 37 * 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cur_col, cur_row;
    logic       test_en;
    logic [2:0] selector, def_selector;
    logic       hsync, vsync, blank_n, frame_start;
    logic       def_hsync, def_vsync, def_blank_n, def_frame_start;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= !rst_n ? 0 : cyc + 1;

    vga_pixel_selector #(
        .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .BOARD_X0(5), .BOARD_Y0(1), .CELL(8), .LINE_W(1), .SPR_MARGIN(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .test_en    (test_en),
        .selector   (selector),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_n    (blank_n),
        .frame_start(frame_start)
    );

    vga_pixel_selector dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .test_en    (test_en),
        .selector   (def_selector),
        .hsync      (def_hsync),
        .vsync      (def_vsync),
        .blank_n    (def_blank_n),
        .frame_start(def_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic at(input int t);
        int n = 0;
        while (cyc != t && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != t) check("wait", 32'(cyc), 32'(t));
    endtask

    task automatic px(input string tag, input int x, input int y, input int f, input int exp);
        at(f * F + 2 * (y * HT + x) + 1);
        check(tag, 32'(selector), 32'(exp));
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_sel"}, 32'(selector), 0);
        check({tag, "_hs"}, 32'(hsync), 1);
        check({tag, "_vs"}, 32'(vsync), 1);
        check({tag, "_blank"}, 32'(blank_n), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_def_hs"}, 32'(def_hsync), 1);
        check({tag, "_def_vs"}, 32'(def_vsync), 1);
        check({tag, "_def_blank"}, 32'(def_blank_n), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cur_col = 2'd3;
        cur_row = 2'd3;
        test_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_state("rst");
        rst_n = 1'b1;
        at(1);    check("fs_c1", 32'(frame_start), 0); check("blank_c1", 32'(blank_n), 0);
        at(2);    check("fs_c2", 32'(frame_start), 1); check("blank_c2", 32'(blank_n), 1);
        at(3);    check("fs_c3", 32'(frame_start), 0);
        at(81);   check("blank_h39", 32'(blank_n), 1);
        at(82);   check("blank_h40", 32'(blank_n), 0);
        at(89);   check("hs_h43", 32'(hsync), 1);
        at(90);   check("hs_h44", 32'(hsync), 0);
        at(101);  check("hs_h49", 32'(hsync), 0);
        at(102);  check("hs_h50", 32'(hsync), 1);
        at(113);  check("blank_h55", 32'(blank_n), 0);
        at(114);  check("blank_l1h0", 32'(blank_n), 1);
        px("hline_20_10", 20, 10, 0, 2);
        at(1281); check("def_blank_h639", 32'(def_blank_n), 1);
        at(1282); check("def_blank_h640", 32'(def_blank_n), 0);
        at(1313); check("def_hs_h655", 32'(def_hsync), 1);
        at(1314); check("def_hs_h656", 32'(def_hsync), 0);
        at(1505); check("def_hs_h751", 32'(def_hsync), 0);
        at(1506); check("def_hs_h752", 32'(def_hsync), 1);
        px("vline0_5_15", 5, 15, 0, 2);
        px("bg_6_15", 6, 15, 0, 0);
        px("bg_35_15", 35, 15, 0, 0);
        px("vline1_14_20", 14, 20, 0, 2);
        px("vline3_32_28", 32, 28, 0, 2);
        px("hl_end_33_28", 33, 28, 0, 0);
        px("vl_end_5_29", 5, 29, 0, 0);
        at(3585); check("vs_v31", 32'(vsync), 1);
        at(3586); check("vs_v32", 32'(vsync), 0);
        cur_col = 2'd1;
        cur_row = 2'd1;
        at(F + 1); check("fs_f1_pre", 32'(frame_start), 0);
        at(F + 2); check("fs_f1", 32'(frame_start), 1);
        at(F + 1344);
        cur_col = 2'd2;
        px("spr_edge_16_13", 16, 13, 1, 0);
        px("spr_17_13", 17, 13, 1, 3);
        px("spr_hold_27_14", 27, 14, 1, 0);
        px("spr_20_16", 20, 16, 1, 3);
        px("spr_end_21_16", 21, 16, 1, 0);
        px("spr_end_18_17", 18, 17, 1, 0);
        px("spr_old_18_14", 18, 14, 2, 0);
        px("spr_new_27_14", 27, 14, 2, 3);
        test_en = 1'b1;
        px("test_0_0", 0, 0, 3, 1);
        px("test_blank_45_5", 45, 5, 3, 0);
        px("test_over_spr", 27, 14, 3, 1);
        px("test_39_29", 39, 29, 3, 1);
        px("test_blank_40_29", 40, 29, 3, 0);
        at(4 * F + 600);
        check("pre_rst_sel", 32'(selector), 1);
        check("pre_rst_blank", 32'(blank_n), 1);
        rst_n = 1'b0;
        @(negedge clk);
        reset_state("midrst");
        rst_n = 1'b1;
        test_en = 1'b0;
        at(1); check("fs_rst_c1", 32'(frame_start), 0);
        at(2); check("fs_rst_c2", 32'(frame_start), 1);
        px("rst_vline0_5_15", 5, 15, 0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
